// File: rtl/y_pkg.sv
// Shared ID/EX definitions: ALU op encodings, the five opcode constants and the
// ID/EX register record. Also intended for use by the ALU.
package y_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alu_op_e;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef struct packed {
        logic            valid;
        logic            regwrite;
        logic            memread;
        logic            memwrite;
        logic            branch;
        logic            illegal;
        alu_op_e         op;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic            use_imm;
    } idex_t;

    function automatic logic funct3_legal(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b111, 3'b110, 3'b010: funct3_legal = 1'b1;
            default:                        funct3_legal = 1'b0;
        endcase
    endfunction

    // Unsupported funct3 falls back to ADD so an illegal slot has a defined op.
    function automatic alu_op_e funct3_to_op(input logic [2:0] f3, input logic sub);
        case (f3)
            3'b000:  funct3_to_op = sub ? ALU_SUB : ALU_ADD;
            3'b111:  funct3_to_op = ALU_AND;
            3'b110:  funct3_to_op = ALU_OR;
            3'b010:  funct3_to_op = ALU_SLT;
            default: funct3_to_op = ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/y_fwd_mux.sv
// One 32-bit operand forwarding selector; EX/MEM has priority over MEM/WB and
// x0 is never forwarded.
module y_fwd_mux
    import y_pkg::*;
(
    input  logic [4:0]      i_rs,
    input  logic [XLEN-1:0] i_reg_value,
    input  logic [4:0]      i_exmem_rd,
    input  logic            i_exmem_regwrite,
    input  logic [XLEN-1:0] i_exmem_value,
    input  logic [4:0]      i_memwb_rd,
    input  logic            i_memwb_regwrite,
    input  logic [XLEN-1:0] i_memwb_value,
    output logic [XLEN-1:0] o_value
);

    logic w_exmem_hit;
    logic w_memwb_hit;

    assign w_exmem_hit = i_exmem_regwrite & (i_exmem_rd != 5'd0) & (i_exmem_rd == i_rs);
    assign w_memwb_hit = i_memwb_regwrite & (i_memwb_rd != 5'd0) & (i_memwb_rd == i_rs);

    // Priority select of the operand source.
    always_comb begin
        o_value = i_reg_value;
        if (w_exmem_hit) begin
            o_value = i_exmem_value;
        end else if (w_memwb_hit) begin
            o_value = i_memwb_value;
        end else begin
            o_value = i_reg_value;
        end
    end

endmodule

// File: rtl/y_id_ex.sv
// ID/EX pipeline stage: decode, load-use hazard detection, the ID/EX register
// with flush/stall/bubble control, and EX-side operand forwarding.
module y_id_ex
    import y_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] insn,
    input  logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] rs1_data,
    input  logic [WIDTH-1:0] rs2_data,
    input  logic [WIDTH-1:0] imm,
    input  logic [4:0]       exmem_rd,
    input  logic             exmem_regwrite,
    input  logic [WIDTH-1:0] exmem_value,
    input  logic [4:0]       memwb_rd,
    input  logic             memwb_regwrite,
    input  logic [WIDTH-1:0] memwb_value,
    output logic             hazard,
    output logic             ex_valid,
    output logic             ex_regwrite,
    output logic             ex_memread,
    output logic             ex_memwrite,
    output logic             ex_branch,
    output logic             ex_illegal,
    output logic [2:0]       ex_op,
    output logic [4:0]       ex_rd,
    output logic [WIDTH-1:0] ex_pc,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [WIDTH-1:0] ex_store_data
);

    idex_t           r_idex;
    idex_t           w_dec;
    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic [4:0]      w_rs1;
    logic [4:0]      w_rs2;
    logic            w_f7b;
    logic            w_rs2_used;
    logic            w_insn_unused;
    logic [XLEN-1:0] w_fwd_rs1;
    logic [XLEN-1:0] w_fwd_rs2;

    assign w_opcode      = insn[6:0];
    assign w_funct3      = insn[14:12];
    assign w_rs1         = insn[19:15];
    assign w_rs2         = insn[24:20];
    assign w_f7b         = insn[30];
    assign w_insn_unused = ^{insn[31], insn[29:25]};

    // Decode the ID instruction into a full ID/EX record.
    always_comb begin
        w_dec          = '0;
        w_dec.valid    = 1'b1;
        w_dec.op       = ALU_ADD;
        w_dec.rd       = insn[11:7];
        w_dec.rs1      = w_rs1;
        w_dec.rs2      = w_rs2;
        w_dec.pc       = pc;
        w_dec.rs1_data = rs1_data;
        w_dec.rs2_data = rs2_data;
        w_dec.imm      = imm;
        w_rs2_used     = 1'b0;
        case (w_opcode)
            OPC_R: begin
                w_rs2_used     = 1'b1;
                w_dec.op       = funct3_to_op(w_funct3, w_f7b);
                w_dec.regwrite = funct3_legal(w_funct3);
                w_dec.illegal  = ~funct3_legal(w_funct3);
            end
            OPC_I: begin
                w_dec.use_imm  = 1'b1;
                w_dec.op       = funct3_to_op(w_funct3, 1'b0);
                w_dec.regwrite = funct3_legal(w_funct3);
                w_dec.illegal  = ~funct3_legal(w_funct3);
            end
            OPC_LOAD: begin
                w_dec.regwrite = 1'b1;
                w_dec.memread  = 1'b1;
                w_dec.use_imm  = 1'b1;
            end
            OPC_STORE: begin
                w_rs2_used     = 1'b1;
                w_dec.memwrite = 1'b1;
                w_dec.use_imm  = 1'b1;
            end
            OPC_BRANCH: begin
                w_rs2_used     = 1'b1;
                w_dec.branch   = 1'b1;
                w_dec.op       = ALU_SUB;
            end
            default: begin
                w_dec.illegal  = 1'b1;
            end
        endcase
    end

    // A load in EX whose destination feeds the ID instruction must stall one slot.
    assign hazard = r_idex.valid & r_idex.memread & (r_idex.rd != 5'd0) & in_valid &
                    ((r_idex.rd == w_rs1) | (w_rs2_used & (r_idex.rd == w_rs2)));

    // ID/EX register: rst > flush > stall > hazard/invalid bubble > capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idex <= '0;
        end else if (flush) begin
            r_idex <= '0;
        end else if (stall) begin
            r_idex <= r_idex;
        end else if (hazard || !in_valid) begin
            r_idex <= '0;
        end else begin
            r_idex <= w_dec;
        end
    end

    y_fwd_mux u_fwd_rs1 (
        .i_rs             (r_idex.rs1),
        .i_reg_value      (r_idex.rs1_data),
        .i_exmem_rd       (exmem_rd),
        .i_exmem_regwrite (exmem_regwrite),
        .i_exmem_value    (exmem_value),
        .i_memwb_rd       (memwb_rd),
        .i_memwb_regwrite (memwb_regwrite),
        .i_memwb_value    (memwb_value),
        .o_value          (w_fwd_rs1)
    );

    y_fwd_mux u_fwd_rs2 (
        .i_rs             (r_idex.rs2),
        .i_reg_value      (r_idex.rs2_data),
        .i_exmem_rd       (exmem_rd),
        .i_exmem_regwrite (exmem_regwrite),
        .i_exmem_value    (exmem_value),
        .i_memwb_rd       (memwb_rd),
        .i_memwb_regwrite (memwb_regwrite),
        .i_memwb_value    (memwb_value),
        .o_value          (w_fwd_rs2)
    );

    assign ex_valid      = r_idex.valid;
    assign ex_regwrite   = r_idex.regwrite;
    assign ex_memread    = r_idex.memread;
    assign ex_memwrite   = r_idex.memwrite;
    assign ex_branch     = r_idex.branch;
    assign ex_illegal    = r_idex.illegal;
    assign ex_op         = r_idex.op;
    assign ex_rd         = r_idex.rd;
    assign ex_pc         = r_idex.pc;
    assign alu_a         = w_fwd_rs1;
    assign alu_b         = r_idex.use_imm ? r_idex.imm : w_fwd_rs2;
    assign ex_store_data = w_fwd_rs2;

endmodule

// File: tb/tb_y_id_ex.sv
// Scoreboard bench for y_id_ex: an independent model predicts each ID/EX slot,
// queues it at drive time and compares it one clock later.
module tb_y_id_ex;

    typedef struct {
        logic        valid, regwrite, memread, memwrite, branch, illegal, use_imm;
        logic [2:0]  op;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] pc, d1, d2, imm;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, stall, flush, in_valid;
    logic [31:0] insn, pc, rs1_data, rs2_data, imm;
    logic [4:0]  exmem_rd, memwb_rd;
    logic        exmem_regwrite, memwb_regwrite;
    logic [31:0] exmem_value, memwb_value;
    logic        hazard, ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_branch, ex_illegal;
    logic [2:0]  ex_op;
    logic [4:0]  ex_rd;
    logic [31:0] ex_pc, alu_a, alu_b, ex_store_data;

    int   n_total = 0;
    int   n_bad   = 0;
    exp_t exp_q[$];
    exp_t m;

    y_id_ex #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
        .insn(insn), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
        .exmem_rd(exmem_rd), .exmem_regwrite(exmem_regwrite), .exmem_value(exmem_value),
        .memwb_rd(memwb_rd), .memwb_regwrite(memwb_regwrite), .memwb_value(memwb_value),
        .hazard(hazard), .ex_valid(ex_valid), .ex_regwrite(ex_regwrite),
        .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ex_branch(ex_branch),
        .ex_illegal(ex_illegal), .ex_op(ex_op), .ex_rd(ex_rd), .ex_pc(ex_pc),
        .alu_a(alu_a), .alu_b(alu_b), .ex_store_data(ex_store_data)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t bubble();
        exp_t e;
        e = '{default: '0};
        return e;
    endfunction

    function automatic exp_t model_dec(input logic [31:0] ins, input logic [31:0] p,
                                       input logic [31:0] a, input logic [31:0] b,
                                       input logic [31:0] im);
        exp_t e;
        logic [6:0] opc;
        logic [2:0] f3;
        e = bubble();
        opc = ins[6:0];
        f3  = ins[14:12];
        e.valid = 1'b1; e.rd = ins[11:7]; e.rs1 = ins[19:15]; e.rs2 = ins[24:20];
        e.pc = p; e.d1 = a; e.d2 = b; e.imm = im; e.op = 3'b010;
        if (opc == 7'h33 || opc == 7'h13) begin
            e.use_imm = (opc == 7'h13);
            if (f3 == 3'd0)      e.op = (opc == 7'h33 && ins[30]) ? 3'b110 : 3'b010;
            else if (f3 == 3'd7) e.op = 3'b000;
            else if (f3 == 3'd6) e.op = 3'b001;
            else if (f3 == 3'd2) e.op = 3'b111;
            else                 e.illegal = 1'b1;
            e.regwrite = ~e.illegal;
        end else if (opc == 7'h03) begin
            e.regwrite = 1'b1; e.memread = 1'b1; e.use_imm = 1'b1;
        end else if (opc == 7'h23) begin
            e.memwrite = 1'b1; e.use_imm = 1'b1;
        end else if (opc == 7'h63) begin
            e.branch = 1'b1; e.op = 3'b110;
        end else begin
            e.illegal = 1'b1;
        end
        return e;
    endfunction

    function automatic logic [31:0] model_fwd(input logic [4:0] rs, input logic [31:0] d);
        if (exmem_regwrite && exmem_rd != 5'd0 && exmem_rd == rs) return exmem_value;
        if (memwb_regwrite && memwb_rd != 5'd0 && memwb_rd == rs) return memwb_value;
        return d;
    endfunction

    function automatic logic model_hazard();
        logic [6:0] opc;
        logic       uses2;
        opc   = insn[6:0];
        uses2 = (opc == 7'h33) || (opc == 7'h23) || (opc == 7'h63);
        return m.valid && m.memread && m.rd != 5'd0 && in_valid &&
               (m.rd == insn[19:15] || (uses2 && m.rd == insn[24:20]));
    endfunction

    function automatic logic [31:0] enc_r(input logic f7b, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {1'b0, f7b, 5'b00000, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] im, input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [6:0] opc);
        return {im, rs1, f3, rd, opc};
    endfunction

    function automatic logic [31:0] enc_s(input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [6:0] opc);
        return {7'd0, rs2, rs1, f3, 5'd0, opc};
    endfunction

    task automatic set_id(input logic [31:0] ins, input logic [31:0] p, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] im);
        insn = ins; pc = p; rs1_data = a; rs2_data = b; imm = im; in_valid = 1'b1;
    endtask

    task automatic set_fwd(input logic xw, input logic [4:0] xr, input logic [31:0] xv,
                           input logic ww, input logic [4:0] wr, input logic [31:0] wv);
        exmem_regwrite = xw; exmem_rd = xr; exmem_value = xv;
        memwb_regwrite = ww; memwb_rd = wr; memwb_value = wv;
    endtask

    task automatic run_cycle();
        exp_t nx;
        logic eh;
        #1;
        eh = model_hazard();
        check_val("hazard", {31'd0, hazard}, {31'd0, eh});
        if (rst)                    nx = bubble();
        else if (flush)             nx = m;
        else if (stall)             nx = m;
        else if (eh || !in_valid)   nx = bubble();
        else                        nx = model_dec(insn, pc, rs1_data, rs2_data, imm);
        if (!rst && flush)          nx = bubble();
        exp_q.push_back(nx);
        @(posedge clk);
        #1;
        m = exp_q.pop_front();
        check_val("valid",    {31'd0, ex_valid},    {31'd0, m.valid});
        check_val("regwrite", {31'd0, ex_regwrite}, {31'd0, m.regwrite});
        check_val("memread",  {31'd0, ex_memread},  {31'd0, m.memread});
        check_val("memwrite", {31'd0, ex_memwrite}, {31'd0, m.memwrite});
        check_val("branch",   {31'd0, ex_branch},   {31'd0, m.branch});
        check_val("illegal",  {31'd0, ex_illegal},  {31'd0, m.illegal});
        check_val("op",       {29'd0, ex_op},       {29'd0, m.op});
        check_val("rd",       {27'd0, ex_rd},       {27'd0, m.rd});
        check_val("pc",       ex_pc,                m.pc);
        check_val("alu_a",    alu_a,                model_fwd(m.rs1, m.d1));
        check_val("alu_b",    alu_b,                m.use_imm ? m.imm : model_fwd(m.rs2, m.d2));
        check_val("store",    ex_store_data,        model_fwd(m.rs2, m.d2));
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        set_id(enc_r(1'b0, 5'd2, 5'd1, 3'd0, 5'd3), 32'h0, 32'd1, 32'd2, 32'd0);
        set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        m = bubble();
        // reset wins over flush/stall
        flush = 1'b1; stall = 1'b1;
        run_cycle();
        rst = 1'b0; flush = 1'b0; stall = 1'b0;

        // add x3,x1,x2
        set_id(enc_r(1'b0, 5'd2, 5'd1, 3'd0, 5'd3), 32'h100, 32'd5, 32'd7, 32'd0);
        run_cycle();
        check_val("req037_op", {29'd0, ex_op}, 32'd2);
        check_val("req037_a", alu_a, 32'd5);
        check_val("req037_b", alu_b, 32'd7);
        // sub x4,x3,x1 with both forwarding sources matching x3
        set_id(enc_r(1'b1, 5'd1, 5'd3, 3'd0, 5'd4), 32'h104, 32'h99, 32'd7, 32'd0);
        set_fwd(1'b1, 5'd3, 32'h10, 1'b1, 5'd3, 32'h20);
        run_cycle();
        check_val("req038_a", alu_a, 32'h10);
        check_val("req038_op", {29'd0, ex_op}, 32'd6);
        // or x5,x4,x3: MEM/WB feeds rs1, EX/MEM feeds rs2
        set_id(enc_r(1'b0, 5'd3, 5'd4, 3'd6, 5'd5), 32'h108, 32'h1, 32'h2, 32'd0);
        set_fwd(1'b1, 5'd3, 32'h10, 1'b1, 5'd4, 32'h20);
        run_cycle();
        set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

        // load-use on rs1
        set_id(enc_i(12'd0, 5'd1, 3'd2, 5'd5, 7'h03), 32'h10c, 32'h40, 32'd0, 32'd0);
        run_cycle();
        set_id(enc_r(1'b0, 5'd2, 5'd5, 3'd0, 5'd6), 32'h110, 32'd3, 32'd4, 32'd0);
        run_cycle();
        check_val("req039_valid", {31'd0, ex_valid}, 32'd0);
        run_cycle();
        // I-type whose imm bits alias rs2 must not hazard; store rs2 must
        set_id(enc_i(12'd0, 5'd1, 3'd2, 5'd8, 7'h03), 32'h114, 32'h40, 32'd0, 32'd4);
        run_cycle();
        set_id(enc_i(12'd8, 5'd1, 3'd0, 5'd9, 7'h13), 32'h118, 32'h11, 32'h22, 32'd8);
        run_cycle();
        set_id(enc_i(12'd0, 5'd1, 3'd2, 5'd8, 7'h03), 32'h11c, 32'h40, 32'd0, 32'd4);
        run_cycle();
        set_id(enc_s(5'd8, 5'd2, 3'd2, 7'h23), 32'h120, 32'h50, 32'h77, 32'hc);
        run_cycle();
        run_cycle();
        // load to x0 never hazards
        set_id(enc_i(12'd0, 5'd1, 3'd2, 5'd0, 7'h03), 32'h124, 32'h40, 32'd0, 32'd0);
        run_cycle();
        set_id(enc_s(5'd0, 5'd0, 3'd0, 7'h63), 32'h128, 32'h5, 32'h6, 32'hfffffff0);
        run_cycle();

        // flush together with stall on a valid ori
        set_id(enc_i(12'h0f0, 5'd2, 3'd6, 5'd10, 7'h13), 32'h12c, 32'h3, 32'h4, 32'hf0);
        flush = 1'b1; stall = 1'b1;
        run_cycle();
        check_val("req040_valid", {31'd0, ex_valid}, 32'd0);
        flush = 1'b0; stall = 1'b0;

        // stall holds for three cycles while ID changes
        set_id(enc_i(12'd9, 5'd3, 3'd2, 5'd11, 7'h13), 32'h130, 32'h8, 32'h9, 32'd9);
        run_cycle();
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            set_id(enc_r(1'b0, 5'(k), 5'(k + 1), 3'd7, 5'(k + 12)), 32'h200 + 32'(k), 32'(k), 32'(k), 32'd0);
            run_cycle();
            check_val("req041_pc", ex_pc, 32'h130);
        end
        stall = 1'b0;
        in_valid = 1'b0;
        run_cycle();

        // x0 is never forwarded; unknown opcode is illegal
        set_fwd(1'b1, 5'd0, 32'hff, 1'b1, 5'd0, 32'hee);
        set_id(enc_r(1'b0, 5'd0, 5'd0, 3'd0, 5'd7), 32'h140, 32'd0, 32'd0, 32'd0);
        run_cycle();
        check_val("req042_a", alu_a, 32'd0);
        set_id({20'h12345, 5'd7, 7'b0110111}, 32'h144, 32'd0, 32'd0, 32'd0);
        run_cycle();
        check_val("req042_ill", {31'd0, ex_illegal}, 32'd1);
        set_id(enc_r(1'b0, 5'd2, 5'd1, 3'd1, 5'd7), 32'h148, 32'd1, 32'd2, 32'd0);
        run_cycle();

        // random mix
        for (int k = 0; k < 80; k++) begin
            logic [4:0]  ra, rb, rdd;
            logic [31:0] w;
            ra = 5'($urandom_range(0, 7)); rb = 5'($urandom_range(0, 7)); rdd = 5'($urandom_range(0, 7));
            case ($urandom_range(0, 6))
                0: w = enc_r(1'($urandom_range(0, 1)), rb, ra, 3'd0, rdd);
                1: w = enc_r(1'b0, rb, ra, 3'($urandom_range(0, 7)), rdd);
                2: w = enc_i(12'($urandom), ra, 3'($urandom_range(0, 7)), rdd, 7'h13);
                3: w = enc_i(12'd4, ra, 3'd2, rdd, 7'h03);
                4: w = enc_s(rb, ra, 3'd2, 7'h23);
                5: w = enc_s(rb, ra, 3'd0, 7'h63);
                default: w = {20'h0, rdd, 7'b0110111};
            endcase
            set_id(w, $urandom, $urandom, $urandom, $urandom);
            in_valid = ($urandom_range(0, 5) != 0);
            stall    = ($urandom_range(0, 4) == 0);
            flush    = ($urandom_range(0, 7) == 0);
            set_fwd(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                    1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
            run_cycle();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
